fifo_packet: RTL

Single-clock, RAM-based packet FIFO with commit/discard semantics on the write side. Written words stay invisible to the reader until the packet's last word is committed. A packet can be dropped mid-write, and a packet that overflows is discarded whole, so the reader never sees a partial packet. It sits between packet producers (for example a UART/Ethernet RX framer with CRC check) and consumers. It supports optional First-Word Fall Through (FWFT) and per-word end-of-packet marking on the read side.

---
 rtl/fifo_packet.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_packet.sv
// Single-clock packet FIFO with commit/discard on the write side: words become
// visible to the reader only once the last word of their packet is committed.
module fifo_packet #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 256,
    parameter int MAKE_FWFT = 0
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic                       i_Wr_DV,
    input  logic [WIDTH-1:0]           i_Wr_Data,
    input  logic                       i_Wr_Last,
    input  logic                       i_Wr_Drop,
    input  logic [$clog2(DEPTH):0]     i_AF_Level,
    output logic                       o_AF_Flag,
    output logic                       o_Full,
    output logic                       o_Overflow,
    input  logic                       i_Rd_En,
    output logic                       o_Rd_DV,
    output logic [WIDTH-1:0]           o_Rd_Data,
    output logic                       o_Rd_Last,
    input  logic [$clog2(DEPTH):0]     i_AE_Level,
    output logic                       o_AE_Flag,
    output logic                       o_Empty,
    output logic [$clog2(DEPTH):0]     o_Word_Count,
    output logic [$clog2(DEPTH):0]     o_Pkt_Count,
    output logic                       o_Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] commit_addr_q, commit_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pending_q, pending_d;
    logic [CW-1:0] pkt_q, pkt_d;
    logic          bad_q, bad_d;
    logic          overflow_q, underflow_q;

    // MSB of each entry is the end-of-packet marker.
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] head_word;

    logic [CW-1:0] used_words, free_words, word_cnt;
    logic          full, wr_accept, wr_commit, wr_reject, ovf_rewind;
    logic          pop_ram, pkt_dec, empty_w, underflow_evt;
    logic          rd_dv_w;
    logic [WIDTH:0] rd_word_w;

    function automatic logic [AW-1:0] inc_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign used_words = count_q + pending_q;
    assign free_words = DEPTH_C - used_words;
    assign full       = (used_words == DEPTH_C);
    assign head_word  = mem[rd_addr_q];

    assign wr_accept  = i_Wr_DV & ~i_Wr_Drop & ~bad_q & ~full;
    assign wr_commit  = wr_accept & i_Wr_Last;
    // A word that finds the FIFO full poisons its packet; the packet's Last rewinds it.
    assign wr_reject  = i_Wr_DV & ~i_Wr_Drop & (bad_q | full);
    assign ovf_rewind = wr_reject & i_Wr_Last;

    always_comb begin
        wr_addr_d     = wr_addr_q;
        commit_addr_d = commit_addr_q;
        pending_d     = pending_q;
        bad_d         = bad_q;
        if (i_Wr_Drop || ovf_rewind) begin
            wr_addr_d = commit_addr_q;
            pending_d = '0;
            bad_d     = 1'b0;
        end else if (wr_accept) begin
            wr_addr_d = inc_addr(wr_addr_q);
            if (i_Wr_Last) begin
                commit_addr_d = inc_addr(wr_addr_q);
                pending_d     = '0;
            end else begin
                pending_d = pending_q + CW'(1);
            end
        end else if (wr_reject) begin
            bad_d = 1'b1;
        end
    end

    always_comb begin
        count_d   = count_q + (wr_commit ? pending_q + CW'(1) : '0) - (pop_ram ? CW'(1) : '0);
        pkt_d     = pkt_q + (wr_commit ? CW'(1) : '0) - (pkt_dec ? CW'(1) : '0);
        rd_addr_d = pop_ram ? inc_addr(rd_addr_q) : rd_addr_q;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            wr_addr_q     <= '0;
            commit_addr_q <= '0;
            rd_addr_q     <= '0;
            count_q       <= '0;
            pending_q     <= '0;
            pkt_q         <= '0;
            bad_q         <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            commit_addr_q <= commit_addr_d;
            rd_addr_q     <= rd_addr_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            pkt_q         <= pkt_d;
            bad_q         <= bad_d;
            overflow_q    <= ovf_rewind;
            underflow_q   <= underflow_evt;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst_L && wr_accept) begin
            mem[wr_addr_q] <= {i_Wr_Last, i_Wr_Data};
        end
    end

    generate
        if (MAKE_FWFT == 0) begin : g_std
            logic           rd_dv_q;
            logic [WIDTH:0] rd_word_q;

            assign pop_ram  = i_Rd_En & (count_q != '0);
            assign pkt_dec  = pop_ram & head_word[WIDTH];
            assign empty_w  = (count_q == '0);
            assign word_cnt = count_q;

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_L) begin
                    rd_dv_q   <= 1'b0;
                    rd_word_q <= '0;
                end else begin
                    rd_dv_q <= pop_ram;
                    if (pop_ram) rd_word_q <= head_word;
                end
            end

            assign rd_dv_w   = rd_dv_q;
            assign rd_word_w = rd_word_q;
        end else begin : g_fwft
            // Two-stage prefetch: a registered RAM read feeding the output register.
            logic           ram_valid_q, out_valid_q;
            logic [WIDTH:0] ram_word_q, out_word_q;
            logic           consume, move;

            assign consume  = i_Rd_En & out_valid_q;
            assign move     = ram_valid_q & (~out_valid_q | consume);
            assign pop_ram  = (count_q != '0) & (~ram_valid_q | move);
            assign pkt_dec  = consume & out_word_q[WIDTH];
            assign empty_w  = ~out_valid_q;
            assign word_cnt = count_q + CW'(ram_valid_q) + CW'(out_valid_q);

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_L) begin
                    ram_valid_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    ram_word_q  <= '0;
                    out_word_q  <= '0;
                end else begin
                    ram_valid_q <= pop_ram | (ram_valid_q & ~move);
                    out_valid_q <= move | (out_valid_q & ~consume);
                    if (pop_ram) ram_word_q <= head_word;
                    if (move)    out_word_q <= ram_word_q;
                end
            end

            assign rd_dv_w   = out_valid_q;
            assign rd_word_w = out_word_q;
        end
    endgenerate

    assign underflow_evt = i_Rd_En & empty_w;

    assign o_Full       = full;
    assign o_AF_Flag    = (free_words <= i_AF_Level);
    assign o_Overflow   = overflow_q;
    assign o_Rd_DV      = rd_dv_w;
    assign o_Rd_Data    = rd_word_w[WIDTH-1:0];
    assign o_Rd_Last    = rd_word_w[WIDTH];
    assign o_AE_Flag    = (word_cnt <= i_AE_Level);
    assign o_Empty      = empty_w;
    assign o_Word_Count = word_cnt;
    assign o_Pkt_Count  = pkt_q;
    assign o_Underflow  = underflow_q;

endmodule
